// File: rtl/int_sched_if.sv
// -----------------------------------------------------------------------------
// int_sched_if
// Bundles the interrupt scheduler's source, qualifier and trap-handshake
// signals.
//   slave  : the scheduler (consumes lines/qualifiers, produces req/cause/status)
//   master : the core/CSR side (drives lines/qualifiers, observes req/cause/status)
// Signals:
//   mtime_interrupt, software_interrupt, external_interrupt : raw level lines
//   mstatus_mie, mie_mtie, mie_msie, mie_meie               : enables
//   instr_valid_ex2, cancel_instr_ex2, is_amo_instr_mem     : take qualifiers
//   trap_ack                                                : handler entered
//   int_req_ex2, int_cause_ex2                              : combinational take
//   int_cause_q                                             : cause latched at take
//   mip_mtip, mip_msip, mip_meip                            : registered pending
//   int_busy, int_timeout                                   : status
// -----------------------------------------------------------------------------
interface int_sched_if;
  logic       mtime_interrupt;
  logic       software_interrupt;
  logic       external_interrupt;
  logic       mstatus_mie;
  logic       mie_mtie;
  logic       mie_msie;
  logic       mie_meie;
  logic       instr_valid_ex2;
  logic       cancel_instr_ex2;
  logic       is_amo_instr_mem;
  logic       trap_ack;
  logic       int_req_ex2;
  logic [3:0] int_cause_ex2;
  logic [3:0] int_cause_q;
  logic       mip_mtip;
  logic       mip_msip;
  logic       mip_meip;
  logic       int_busy;
  logic       int_timeout;

  modport slave (
    input  mtime_interrupt, software_interrupt, external_interrupt,
           mstatus_mie, mie_mtie, mie_msie, mie_meie,
           instr_valid_ex2, cancel_instr_ex2, is_amo_instr_mem, trap_ack,
    output int_req_ex2, int_cause_ex2, int_cause_q,
           mip_mtip, mip_msip, mip_meip, int_busy, int_timeout
  );

  modport master (
    output mtime_interrupt, software_interrupt, external_interrupt,
           mstatus_mie, mie_mtie, mie_msie, mie_meie,
           instr_valid_ex2, cancel_instr_ex2, is_amo_instr_mem, trap_ack,
    input  int_req_ex2, int_cause_ex2, int_cause_q,
           mip_mtip, mip_msip, mip_meip, int_busy, int_timeout
  );
endinterface

// File: rtl/int_sched.sv
// -----------------------------------------------------------------------------
// int_sched
// Machine-mode interrupt scheduler for the EX2 stage. Registers the raw
// interrupt lines into mip bits, picks the highest-priority enabled source
// (MEI > MSI > MTI), raises a one-cycle take against a safe EX2 instruction,
// then sequences the trap handshake: WAIT_ACK (bounded by ACK_TIMEOUT),
// HOLDOFF (HOLDOFF_CYCLES), back to IDLE. Only one interrupt is in flight.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : int_sched_if.slave (see interface header for signal list)
// -----------------------------------------------------------------------------
module int_sched #(
  parameter int ACK_TIMEOUT    = 16,  // 1..255
  parameter int HOLDOFF_CYCLES = 2    // 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  int_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    HOLDOFF  = 2'd2
  } state_t;

  localparam logic [7:0] ACK_TO = 8'(ACK_TIMEOUT);
  localparam logic [7:0] HOLD   = 8'(HOLDOFF_CYCLES);

  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_cause_q;
  logic       r_timeout;
  logic       r_mtip, r_msip, r_meip;

  logic [2:0] w_elig;
  logic [3:0] w_cause;
  logic       w_take;
  logic [7:0] w_cnt_inc;

  // Pending bits follow the lines one cycle late; they are level, not sticky.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtip <= 1'b0;
      r_msip <= 1'b0;
      r_meip <= 1'b0;
    end else begin
      r_mtip <= bus.mtime_interrupt;
      r_msip <= bus.software_interrupt;
      r_meip <= bus.external_interrupt;
    end
  end

  assign w_elig = {r_meip & bus.mie_meie, r_msip & bus.mie_msie, r_mtip & bus.mie_mtie};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_cause = 4'd0;
    if (w_elig[2])      w_cause = CAUSE_MEI;
    else if (w_elig[1]) w_cause = CAUSE_MSI;
    else if (w_elig[0]) w_cause = CAUSE_MTI;
  end

  assign w_take = (r_state == IDLE) & bus.mstatus_mie & (|w_elig) &
                  bus.instr_valid_ex2 & ~bus.cancel_instr_ex2 & ~bus.is_amo_instr_mem;

  // Counter saturates at ACK_TIMEOUT instead of wrapping.
  assign w_cnt_inc = (r_cnt == ACK_TO) ? r_cnt : r_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_cause_q <= 4'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            r_cause_q <= w_cause;
            r_cnt     <= 8'd0;
            r_state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // Ack has priority over a timeout expiring in the same cycle.
          if (bus.trap_ack) begin
            r_cnt   <= HOLD;
            r_state <= HOLDOFF;
          end else if (w_cnt_inc == ACK_TO) begin
            r_cnt     <= w_cnt_inc;
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        HOLDOFF: begin
          // Loaded with HOLDOFF_CYCLES; leaving at 1 gives exactly that many
          // HOLDOFF cycles before IDLE.
          if (r_cnt <= 8'd1) begin
            r_cnt   <= 8'd0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_cnt   <= 8'd0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.int_req_ex2   = w_take;
  assign bus.int_cause_ex2 = w_cause;
  assign bus.int_cause_q   = r_cause_q;
  assign bus.mip_mtip      = r_mtip;
  assign bus.mip_msip      = r_msip;
  assign bus.mip_meip      = r_meip;
  assign bus.int_busy      = (r_state != IDLE);
  assign bus.int_timeout   = r_timeout;

endmodule

// File: doc/int_sched.md
# int_sched

Machine-mode interrupt scheduler for the core's EX2 stage. It registers the raw CLINT/PLIC/software interrupt lines into pending bits and selects the highest-priority enabled source. It raises a one-cycle take request against a safe EX2 instruction, then sequences the trap handshake: wait for acknowledge, bounded timeout, post-trap holdoff. It sits between the interrupt sources and the CSR/trap unit, so one interrupt is in flight at a time and it cannot be re-taken before `mstatus.MIE` is cleared.

## Interface
Parameters:
- `ACK_TIMEOUT`, 16, cycles in WAIT_ACK before abandoning a take. Legal range 1..255.
- `HOLDOFF_CYCLES`, 2, cycles in HOLDOFF after acknowledge. Legal range 1..15.

Ports:
- `clk`  in  1  core clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mtime_interrupt`  in  1  timer line from CLINT, level.
- `software_interrupt`  in  1  msip from CLINT, level.
- `external_interrupt`  in  1  line from PLIC, level.
- `mstatus_mie`  in  1  global machine interrupt enable.
- `mie_mtie`, `mie_msie`, `mie_meie`  in  1 each  per-source enables.
- `instr_valid_ex2`  in  1  valid instruction present in EX2.
- `cancel_instr_ex2`  in  1  EX2 instruction is being cancelled.
- `is_amo_instr_mem`  in  1  AMO in MEM; blocks take.
- `trap_ack`  in  1  trap unit has entered the handler.
- `int_req_ex2`  out  1  take interrupt on the current EX2 instruction. Combinational.
- `int_cause_ex2`  out  4  cause code, valid only with `int_req_ex2`. Combinational.
- `int_cause_q`  out  4  cause latched at take, for the mcause write.
- `mip_mtip`, `mip_msip`, `mip_meip`  out  1 each  registered pending bits.
- `int_busy`  out  1  state is not IDLE.
- `int_timeout`  out  1  one-cycle pulse when a take is abandoned.

## Operation
- Each cycle, the `mip_*` bits are loaded from the raw lines. They are level, not sticky.
- `elig = {mip_meip&mie_meie, mip_msip&mie_msie, mip_mtip&mie_mtie}`.
- Priority: MEI (cause 11) > MSI (3) > MTI (7). `int_cause_ex2` outputs 0 when nothing is eligible.
- `take = (state==IDLE) & mstatus_mie & |elig & instr_valid_ex2 & !cancel_instr_ex2 & !is_amo_instr_mem`.
- `int_req_ex2 = take`. `int_cause_ex2` is the prioritized code.
- FSM with 2-bit state:
  - IDLE: on `take`, latch `int_cause_q`, clear the counter, go to WAIT_ACK.
  - WAIT_ACK: if `trap_ack`, load the holdoff counter and go to HOLDOFF. Otherwise increment the counter. When the counter reaches `ACK_TIMEOUT` with no ack, go to IDLE and set `int_timeout` for one cycle.
  - HOLDOFF: decrement the counter. At 0, go to IDLE. `trap_ack` is ignored.
- `trap_ack` is ignored in IDLE and HOLDOFF, and in the take cycle itself.
- Simultaneous ack and timeout expiry in the same cycle: ack wins, go to HOLDOFF, no `int_timeout`.
- `int_cause_q` holds its value until the next take. Timeout does not clear it.
- Lines dropping while in WAIT_ACK or HOLDOFF have no effect on the FSM.
- Counter is 8 bits and never wraps; it saturates at `ACK_TIMEOUT`.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE, counter=0, `int_cause_q`=0, all `mip_*`=0, `int_timeout`=0, `int_busy`=0. `int_req_ex2`=0 while in reset.
- Reset asserted mid-WAIT_ACK or mid-HOLDOFF returns all state to the reset values immediately.
- Latency: a line rising at edge N sets `mip_*` at N+1. The earliest `int_req_ex2` is in cycle N+1, same cycle as the qualifiers.
- Take in cycle T: WAIT_ACK for cycles T+1..T+ACK_TIMEOUT.
- Timeout: with no ack, IDLE at T+ACK_TIMEOUT+1, with `int_timeout`=1 in that cycle only.
- Ack in cycle A: HOLDOFF for cycles A+1..A+HOLDOFF_CYCLES, IDLE at A+HOLDOFF_CYCLES+1. The next take can occur in that cycle.
- `int_req_ex2` is high for at most one cycle per take.

## Test plan
- Timer only, `mie_mtie`=1, `mstatus_mie`=1, valid EX2: line rises at edge 10 -> `int_req_ex2`=1 and `int_cause_ex2`=7 in cycle 11. `int_cause_q`=7 and `int_busy`=1 from cycle 12.
- Timer and external both pending, both enabled -> cause 11. Clear `mie_meie` -> cause 7. Add msip with `mie_msie`=1 -> cause 3.
- Pending and enabled, but `cancel_instr_ex2`=1, or `is_amo_instr_mem`=1, or `instr_valid_ex2`=0 -> `int_req_ex2`=0 while the condition holds. Request fires in the first cycle all qualifiers clear.
- Take at T, `trap_ack` at T+3, `HOLDOFF_CYCLES`=2 -> HOLDOFF in T+4..T+5, IDLE at T+6. No request in T+1..T+5 despite the line held high.
- `ACK_TIMEOUT`=16, no ack -> `int_timeout` pulses at T+17 and a re-take is possible at T+17. With ack arriving exactly at T+16 instead -> HOLDOFF, no pulse.
- `rst_n` low in WAIT_ACK with the line high -> all outputs 0 immediately. After release, `mip` reloads next edge and the request re-fires one cycle later.
